// File: rtl/xc_rf_wr_sched.sv
// GPR write-port scheduler: round-robin between pipeline (req0) and long-latency (req1) writeback,
// plus a busy scoreboard for read hazards. Optional XC_RF_SCHED_PERF_EN adds conflict_count.
module xc_rf_wr_sched (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic [4:0]  iss_addr,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rs3_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        rs3_busy,
  output logic        rd_wen,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata
`ifdef XC_RF_SCHED_PERF_EN
  ,output logic [31:0] conflict_count
`endif
);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] wdata;
  } wr_req_t;

  logic [31:0] busy, busy_nxt;
  logic        last;
  logic        e0, e1, grant0, grant1, xfer;
  wr_req_t     win;

  // req0 must not overtake a pending long-latency result to the same GPR
  assign e0     = req0_valid && !busy[req0_addr];
  assign e1     = req1_valid;
  assign grant0 = e0 && (!e1 || last);
  assign grant1 = e1 && (!e0 || !last);
  assign xfer   = grant0 || grant1;
  assign win    = grant1 ? '{addr: req1_addr, wdata: req1_wdata}
                         : '{addr: req0_addr, wdata: req0_wdata};

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign iss_ready  = !busy[iss_addr];
  assign rs1_busy   = busy[rs1_addr] && |rs1_addr;
  assign rs2_busy   = busy[rs2_addr] && |rs2_addr;
  assign rs3_busy   = busy[rs3_addr] && |rs3_addr;

  always_comb begin
    busy_nxt = busy;
    if (grant1) busy_nxt[req1_addr] = 1'b0;
    if (iss_valid && iss_ready) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      last     <= 1'b1;
      rd_wen   <= 1'b0;
      rd_addr  <= '0;
      rd_wdata <= '0;
    end else begin
      busy   <= busy_nxt;
      rd_wen <= xfer && |win.addr;
      if (xfer) begin
        last     <= grant1;
        rd_addr  <= win.addr;
        rd_wdata <= win.wdata;
      end
    end
  end

`ifdef XC_RF_SCHED_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         conflict_count <= '0;
    else if (e0 && e1) conflict_count <= conflict_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_xc_rf_wr_sched.sv
// Bench for xc_rf_wr_sched: directed vector table, reset corner, and randomized run against a model.
module tb_xc_rf_wr_sched;

  logic        clock = 1'b0, reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready, iss_valid, iss_ready;
  logic [4:0]  req0_addr, req1_addr, iss_addr, rs1_addr, rs2_addr, rs3_addr, rd_addr;
  logic [31:0] req0_wdata, req1_wdata, rd_wdata;
  logic        rs1_busy, rs2_busy, rs3_busy, rd_wen;
`ifdef XC_RF_SCHED_PERF_EN
  logic [31:0] conflict_count;
`endif

  xc_rf_wr_sched dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_addr(iss_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs3_addr(rs3_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs3_busy(rs3_busy),
    .rd_wen(rd_wen), .rd_addr(rd_addr), .rd_wdata(rd_wdata)
`ifdef XC_RF_SCHED_PERF_EN
    ,.conflict_count(conflict_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic r0v; logic [4:0] r0a; logic [31:0] r0d;
    logic r1v; logic [4:0] r1a; logic [31:0] r1d;
    logic iv;  logic [4:0] ia;
    logic [4:0] rs1, rs2, rs3;
    logic x_r0, x_r1, x_is; logic [2:0] x_rsb;
    logic x_wen, chk_ad; logic [4:0] x_addr; logic [31:0] x_data;
  } vec_t;

  function automatic vec_t mk(
      logic r0v, logic [4:0] r0a, logic [31:0] r0d, logic r1v, logic [4:0] r1a, logic [31:0] r1d,
      logic iv, logic [4:0] ia, logic [4:0] s1, logic [4:0] s2, logic [4:0] s3,
      logic x_r0, logic x_r1, logic x_is, logic [2:0] x_rsb,
      logic x_wen, logic chk_ad, logic [4:0] x_addr, logic [31:0] x_data);
    vec_t v;
    v.r0v = r0v; v.r0a = r0a; v.r0d = r0d; v.r1v = r1v; v.r1a = r1a; v.r1d = r1d;
    v.iv = iv; v.ia = ia; v.rs1 = s1; v.rs2 = s2; v.rs3 = s3;
    v.x_r0 = x_r0; v.x_r1 = x_r1; v.x_is = x_is; v.x_rsb = x_rsb;
    v.x_wen = x_wen; v.chk_ad = chk_ad; v.x_addr = x_addr; v.x_data = x_data;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req0_valid = v.r0v; req0_addr = v.r0a; req0_wdata = v.r0d;
    req1_valid = v.r1v; req1_addr = v.r1a; req1_wdata = v.r1d;
    iss_valid = v.iv; iss_addr = v.ia;
    rs1_addr = v.rs1; rs2_addr = v.rs2; rs3_addr = v.rs3;
  endtask

  task automatic idle();
    drive(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0));
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Reference model: scoreboard as a set of pending GPRs, tie-break by who goes next
  bit          m_pend[32];
  int          m_next_tie;   // requester that wins the next tie
  bit          m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data, m_cc;
  int          m_win;
  bit          m_both;

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_next_tie = 0; m_wen = 0; m_addr = 0; m_data = 0; m_cc = 0;
  endtask

  task automatic model_eval();
    bit el0, el1;
    el0 = req0_valid && !m_pend[req0_addr];
    el1 = req1_valid;
    m_both = el0 && el1;
    if (m_both)   m_win = m_next_tie;
    else if (el0) m_win = 0;
    else if (el1) m_win = 1;
    else          m_win = -1;
  endtask

  task automatic model_commit();
    bit iss_ok;
    iss_ok = (iss_addr == 0) || !m_pend[iss_addr];
    m_cc = m_cc + (m_both ? 32'd1 : 32'd0);
    m_wen = 0;
    if (m_win >= 0) begin
      m_next_tie = 1 - m_win;
      m_addr = (m_win == 1) ? req1_addr : req0_addr;
      m_data = (m_win == 1) ? req1_wdata : req0_wdata;
      m_wen  = (m_addr != 0);
      if (m_win == 1) m_pend[req1_addr] = 0;
    end
    if (iss_valid && iss_ok && iss_addr != 0) m_pend[iss_addr] = 1;
  endtask

  vec_t tbl[17];

  initial begin
    reset = 1'b1;
    idle();
    tbl[0]  = mk(1,1,'h11,       1,2,'h22,  0,0, 0,0,0, 1,0,1,3'b000, 1,1,1,'h11);
    tbl[1]  = mk(1,1,'h13,       1,2,'h22,  0,0, 0,0,0, 0,1,1,3'b000, 1,1,2,'h22);
    tbl[2]  = mk(1,1,'h13,       1,4,'h44,  0,0, 0,0,0, 1,0,1,3'b000, 1,1,1,'h13);
    tbl[3]  = mk(1,5,'h55,       1,4,'h44,  0,0, 0,0,0, 0,1,1,3'b000, 1,1,4,'h44);
    tbl[4]  = mk(1,3,'hDEADBEEF, 0,0,0,     0,0, 0,0,0, 1,0,1,3'b000, 1,1,3,'hDEADBEEF);
    tbl[5]  = mk(0,0,0,          0,0,0,     1,7, 0,7,0, 0,0,1,3'b000, 0,1,3,'hDEADBEEF);
    tbl[6]  = mk(1,7,'h77,       0,0,0,     0,7, 0,7,0, 0,0,0,3'b010, 0,1,3,'hDEADBEEF);
    tbl[7]  = mk(1,7,'h77,       1,7,'h70,  0,7, 0,7,0, 0,1,0,3'b010, 1,1,7,'h70);
    tbl[8]  = mk(1,7,'h77,       0,0,0,     0,7, 0,7,0, 1,0,1,3'b000, 1,1,7,'h77);
    tbl[9]  = mk(1,0,'h99,       0,0,0,     0,0, 0,0,0, 1,0,1,3'b000, 0,0,0,0);
    tbl[10] = mk(0,0,0,          0,0,0,     1,9, 0,0,0, 0,0,1,3'b000, 0,0,0,0);
    tbl[11] = mk(0,0,0,          0,0,0,     1,9, 9,0,9, 0,0,0,3'b101, 0,0,0,0);
    tbl[12] = mk(0,0,0,          1,9,'h909, 1,9, 9,0,9, 0,1,0,3'b101, 1,1,9,'h909);
    tbl[13] = mk(0,0,0,          0,0,0,     1,9, 9,0,0, 0,0,1,3'b000, 0,1,9,'h909);
    tbl[14] = mk(0,0,0,          0,0,0,     0,9, 9,0,0, 0,0,0,3'b001, 0,1,9,'h909);
    tbl[15] = mk(0,0,0,          1,12,'hC,  0,0, 0,9,0, 0,1,1,3'b010, 1,1,12,'hC);
    tbl[16] = mk(0,0,0,          0,0,0,     0,0, 9,12,0,0,0,1,3'b001, 0,1,12,'hC);

    @(negedge clock);
    do_reset();

    // reset state
    #1;
    chk("rst_rd_wen", rd_wen, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_wdata", rd_wdata, 0);
`ifdef XC_RF_SCHED_PERF_EN
    chk("rst_conflict_count", conflict_count, 0);
`endif

    // reset mid-operation: x5 busy, req0 in flight when reset hits
    @(negedge clock);
    iss_valid = 1; iss_addr = 5;
    @(negedge clock);
    iss_valid = 0; rs1_addr = 5; rs2_addr = 5; rs3_addr = 5;
    #1;
    chk("midrst_busy_before", {rs3_busy, rs2_busy, rs1_busy}, 3'b111);
    chk("midrst_iss_ready_before", iss_ready, 0);
    req0_valid = 1; req0_addr = 6; req0_wdata = 'h66;
    #1;
    chk("midrst_req0_ready", req0_ready, 1);
    reset = 1;
    #1;
    chk("midrst_async_busy", {rs3_busy, rs2_busy, rs1_busy}, 3'b000);
    @(posedge clock);
    @(negedge clock);
    reset = 0; req0_valid = 0;
    #1;
    chk("midrst_rd_wen", rd_wen, 0);
    chk("midrst_rd_addr", rd_addr, 0);
    chk("midrst_rd_wdata", rd_wdata, 0);
    chk("midrst_iss_ready", iss_ready, 1);
    @(posedge clock);
    @(negedge clock);
    chk("midrst_discarded", rd_wen, 0);

    // directed table from a fresh reset
    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      if (tbl[i].r0v) chk($sformatf("t%0d_req0_ready", i), req0_ready, tbl[i].x_r0);
      if (tbl[i].r1v) chk($sformatf("t%0d_req1_ready", i), req1_ready, tbl[i].x_r1);
      chk($sformatf("t%0d_one_ready", i), req0_ready && req1_ready, 0);
      chk($sformatf("t%0d_iss_ready", i), iss_ready, tbl[i].x_is);
      chk($sformatf("t%0d_rs_busy", i), {rs3_busy, rs2_busy, rs1_busy}, tbl[i].x_rsb);
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("t%0d_rd_wen", i), rd_wen, tbl[i].x_wen);
      if (tbl[i].chk_ad) begin
        chk($sformatf("t%0d_rd_addr", i), rd_addr, tbl[i].x_addr);
        chk($sformatf("t%0d_rd_wdata", i), rd_wdata, tbl[i].x_data);
      end
`ifdef XC_RF_SCHED_PERF_EN
      if (i == 3) chk("t3_conflict_count", conflict_count, 4);
`endif
    end

    // randomized run against the model
    do_reset();
    model_reset();
    begin
      bit hold0 = 0, hold1 = 0;
      for (int c = 0; c < 600; c++) begin
        if (!hold0) begin
          req0_valid = ($urandom % 3) != 0; req0_addr = 5'($urandom % 8); req0_wdata = $urandom;
        end
        if (!hold1) begin
          req1_valid = ($urandom % 3) == 0; req1_addr = 5'($urandom % 8); req1_wdata = $urandom;
        end
        iss_valid = ($urandom % 3) == 0; iss_addr = 5'($urandom % 8);
        rs1_addr = 5'($urandom % 8); rs2_addr = 5'($urandom % 8); rs3_addr = 5'($urandom % 8);
        #1;
        model_eval();
        if (req0_valid) chk("rnd_req0_ready", req0_ready, m_win == 0);
        if (req1_valid) chk("rnd_req1_ready", req1_ready, m_win == 1);
        chk("rnd_iss_ready", iss_ready, !m_pend[iss_addr]);
        chk("rnd_rs_busy", {rs3_busy, rs2_busy, rs1_busy},
            {m_pend[rs3_addr] && rs3_addr != 0, m_pend[rs2_addr] && rs2_addr != 0,
             m_pend[rs1_addr] && rs1_addr != 0});
        hold0 = req0_valid && m_win != 0;
        hold1 = req1_valid && m_win != 1;
        @(posedge clock);
        model_commit();
        @(negedge clock);
        chk("rnd_rd_wen", rd_wen, m_wen);
        chk("rnd_rd_addr", rd_addr, m_addr);
        chk("rnd_rd_wdata", rd_wdata, m_data);
`ifdef XC_RF_SCHED_PERF_EN
        chk("rnd_conflict_count", conflict_count, m_cc);
`endif
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
